// File: rtl/gals_sender_if.sv
// ============================================================
// gals_sender_if : generator-side and consumer-side signals of the sender
// Rev 1.0
// ============================================================
`default_nettype none

interface gals_sender_if #(
  parameter int WIDTH = 16
);
  logic             f_valid;
  logic [WIDTH-1:0] f_out;
  logic             f_en;
  logic             ack;
  logic             req;
  logic [WIDTH-1:0] data_out;
  logic             overflow;

  modport master (
    input  f_valid, f_out, ack,
    output f_en, req, data_out, overflow
  );

  modport slave (
    output f_valid, f_out, ack,
    input  f_en, req, data_out, overflow
  );
endinterface

`default_nettype wire

// File: rtl/gals_sender.sv
// ============================================================
// gals_sender : producer-domain FIFO plus 4-phase req/ack sender
// Rev 1.0
// ============================================================
`default_nettype none

module gals_sender #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic           clock_1,
  input  logic           reset,
  gals_sender_if.master  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic [AW+1:0]    count_plus;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             ack_meta;
  logic             ack_s;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             req_q;
  logic             req_next;
  logic [WIDTH-1:0] data_q;
  logic             overflow_q;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Counting the in-flight f_valid covers the generator's enable-to-valid latency
  assign count_plus = {1'b0, count} + {{(AW+1){1'b0}}, bus.f_valid};
  assign bus.f_en   = (count_plus < {1'b0, FULL_COUNT});

  assign pop  = (state == IDLE) && !empty && !ack_s;
  assign push = bus.f_valid && (!full || pop);

  assign bus.req      = req_q;
  assign bus.data_out = data_q;
  assign bus.overflow = overflow_q;

  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= bus.ack;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge clock_1) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.f_out;
    end
  end

  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= mem[rd_ptr[AW-1:0]];
      end
      if (bus.f_valid && full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else begin
      state <= state_next;
      req_q <= req_next;
    end
  end

  always_comb begin
    state_next = state;
    req_next   = req_q;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        req_next   = 1'b1;
        state_next = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          req_next   = 1'b0;
          state_next = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: doc/gals_sender.md
# gals_sender

Producer-side boundary stage of the GALS producer/consumer link, clocked in the producer domain (`clock_1`). It captures every valid word from the Fibonacci generator into a small FIFO and throttles the generator through `f_en` so no word is ever lost. It forwards each word across the clock boundary with a 4-phase req/ack handshake. `ack` arrives from the consumer domain and is synchronized internally.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `WIDTH`, 16: data width; matches generator output.

- `clock_1`  in  1  producer-domain clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `f_valid`  in  1  generator word valid, one cycle per word.
- `f_out`  in  WIDTH  generator word; sampled when `f_valid`=1.
- `f_en`  out  1  generator enable, combinational.
- `ack`  in  1  consumer acknowledge; asynchronous to `clock_1`.
- `req`  out  1  handshake request, registered.
- `data_out`  out  WIDTH  word presented to consumer, registered.
- `overflow`  out  1  sticky error flag: a word arrived while the FIFO was full.

## Operation
- FIFO:
  - Circular buffer with `DEPTH` entries.
  - Read/write pointers are log2(DEPTH)+1 bits (extra wrap bit).
  - `count` = wr_ptr − rd_ptr (modulo); full when `count`=DEPTH, empty when 0.
- Write: on an edge where `f_valid`=1 and not full, store `f_out` and increment wr_ptr.
- Full write: if `f_valid`=1 while full, drop the word and set `overflow`=1. `overflow` clears only on reset.
- Simultaneous push and pop on the same edge: both happen, `count` is unchanged. Push is allowed when full only if a pop occurs on that edge.
- Flow control: `f_en` = (count + f_valid) < DEPTH.
  - This covers the generator's one-cycle enable-to-valid latency.
  - With compliant upstream, `overflow` never sets.
- Synchronizer: `ack` passes through 2 flops (reset 0) to give `ack_s`. The FSM uses only `ack_s`.
- FSM states: IDLE, LOAD, REQ_HI, REQ_LO.
  - IDLE: if FIFO not empty and `ack_s`=0, pop head into `data_out`, go to LOAD. Otherwise stay.
  - LOAD: `req` is still 0 (data setup cycle). Set `req`=1, go to REQ_HI.
  - REQ_HI: wait for `ack_s`=1, then set `req`=0, go to REQ_LO.
  - REQ_LO: wait for `ack_s`=0, then go to IDLE.
- `data_out` changes only on IDLE→LOAD. It is stable for the whole req/ack cycle and holds its last value afterward.
- Words leave in strict FIFO order; none is duplicated or skipped.

## Timing
- Reset values:
  - `req`=0, `data_out`=0, `overflow`=0.
  - FSM=IDLE, pointers=0, sync flops=0.
  - `f_en`=1 while reset is high and after release (follows count=0, f_valid=0).
- Latency, word written at edge t with FSM idle and `ack_s`=0:
  - popped into `data_out` at edge t+1;
  - `req` rises at edge t+2.
- Ack path: `ack` rising before edge k gives `ack_s`=1 after edge k+1 and `req` falls at edge k+2. The falling edge of `ack` has the same 2-cycle synchronizer delay.
- Minimum handshake period is 8 edges, so steady-state throughput is bounded by consumer ack speed.
- `req` is glitch-free (registered); `f_en` is combinational from registered state plus `f_valid`.
- Reset mid-handshake: `req` drops to 0 at once and the FIFO is emptied. The consumer is required to be reset together with the sender.

## Test plan
- Reset check: assert `reset` mid-run → `req`=0, `data_out`=0, `overflow`=0, `f_en`=1, and no `req` activity until a new `f_valid` arrives.
- Single word: one `f_valid` with `f_out`=16'h0005, responder acks 3 cycles after `req` rises → `data_out`=5 one edge before `req` rises, `req` rises 2 edges after the write, `req` falls 2 edges after `ack` rises.
- Stream order: generator connected, responder with random 0–5 cycle ack delay, 20 words → consumer receives 0,1,1,2,3,5,8,13,… in order with no gaps; `overflow`=0.
- Backpressure: `ack` held 0 → FIFO fills to exactly DEPTH, `f_en` falls to 0 with count+f_valid=DEPTH, `overflow` stays 0; releasing acks drains the FIFO and `f_en` returns to 1.
- Overflow: force `f_valid`=1 while full → `overflow`=1 and stays 1, and the stored FIFO contents are unchanged.
- Wrap-around: transfer 3×DEPTH+1 words with simultaneous push/pop edges → pointers wrap, `count` stays correct, and the data sequence is intact.
